// File: rtl/morse_decoder_fifo.sv
// Morse decoder: accumulates dot/dash symbols, resolves a character on send,
// and queues the decoded ASCII in a small FIFO drained by a valid/ready consumer.
//
// Ports:
//   clk          single clock, all logic on posedge
//   reset        synchronous active-high reset
//   inputSignal  symbol code: 00 idle, 01 dot, 10 dash, 11 send
//   out_ready    consumer accepts the head character
//   letter       ASCII at the FIFO head (0x00 while empty)
//   out_valid    FIFO non-empty
//   done         accumulator empty (state IDLE)
//   sym_len      symbols accumulated so far
//   fifo_count   FIFO occupancy
//   err          one-cycle pulse after an invalid or overrun character is emitted
//   drop         one-cycle pulse after a character is lost to a full FIFO
module morse_decoder_fifo #(
    parameter int MAX_LEN    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int EN_DIGITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    inputSignal,
    input  logic                          out_ready,
    output logic [7:0]                    letter,
    output logic                          out_valid,
    output logic                          done,
    output logic [2:0]                    sym_len,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err,
    output logic                          drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] MAXL = 3'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [MAX_LEN-1:0]   pattern, pattern_nxt;
    logic [2:0]           len, len_nxt;

    logic                 is_sym, is_send, sym_bit;
    logic                 push, bad;
    logic [7:0]           push_char;

    logic [5:0]           pat6;
    logic [7:0]           code_key;
    logic                 dec_valid;
    logic [7:0]           dec_char;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 pop, full, push_ok, lost;

    assign is_sym  = (inputSignal == 2'b01) || (inputSignal == 2'b10);
    assign is_send = (inputSignal == 2'b11);
    assign sym_bit = inputSignal[1];

    // Bits above len stay zero (pattern is cleared on every send), so the
    // low five bits together with len identify a code uniquely.
    assign pat6     = 6'(pattern);
    assign code_key = {len, pat6[4:0]};

    always_comb begin
        dec_valid = 1'b1;
        dec_char  = 8'h3F;
        case (code_key)
            8'b001_00000: dec_char = 8'h45; // E
            8'b001_00001: dec_char = 8'h54; // T
            8'b010_00000: dec_char = 8'h49; // I
            8'b010_00001: dec_char = 8'h41; // A
            8'b010_00010: dec_char = 8'h4E; // N
            8'b010_00011: dec_char = 8'h4D; // M
            8'b011_00000: dec_char = 8'h53; // S
            8'b011_00001: dec_char = 8'h55; // U
            8'b011_00010: dec_char = 8'h52; // R
            8'b011_00011: dec_char = 8'h57; // W
            8'b011_00100: dec_char = 8'h44; // D
            8'b011_00101: dec_char = 8'h4B; // K
            8'b011_00110: dec_char = 8'h47; // G
            8'b011_00111: dec_char = 8'h4F; // O
            8'b100_00000: dec_char = 8'h48; // H
            8'b100_00001: dec_char = 8'h56; // V
            8'b100_00010: dec_char = 8'h46; // F
            8'b100_00100: dec_char = 8'h4C; // L
            8'b100_00110: dec_char = 8'h50; // P
            8'b100_00111: dec_char = 8'h4A; // J
            8'b100_01000: dec_char = 8'h42; // B
            8'b100_01001: dec_char = 8'h58; // X
            8'b100_01010: dec_char = 8'h43; // C
            8'b100_01011: dec_char = 8'h59; // Y
            8'b100_01100: dec_char = 8'h5A; // Z
            8'b100_01101: dec_char = 8'h51; // Q
            8'b101_11111: dec_char = 8'h30;
            8'b101_01111: dec_char = 8'h31;
            8'b101_00111: dec_char = 8'h32;
            8'b101_00011: dec_char = 8'h33;
            8'b101_00001: dec_char = 8'h34;
            8'b101_00000: dec_char = 8'h35;
            8'b101_10000: dec_char = 8'h36;
            8'b101_11000: dec_char = 8'h37;
            8'b101_11100: dec_char = 8'h38;
            8'b101_11110: dec_char = 8'h39;
            default: begin
                dec_valid = 1'b0;
                dec_char  = 8'h3F;
            end
        endcase
        // Five-symbol codes are all digits; reject them when digits are off.
        if ((code_key[7:5] == 3'd5) && (EN_DIGITS == 0)) begin
            dec_valid = 1'b0;
            dec_char  = 8'h3F;
        end
    end

    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        len_nxt     = len;
        push        = 1'b0;
        push_char   = 8'h00;
        bad         = 1'b0;
        case (state)
            IDLE: begin
                if (is_sym) begin
                    state_nxt   = COLLECT;
                    pattern_nxt = MAX_LEN'(sym_bit);
                    len_nxt     = 3'd1;
                end else if (is_send) begin
                    push      = 1'b1;
                    push_char = 8'h20;
                end
            end
            COLLECT: begin
                if (is_sym) begin
                    if (len == MAXL) begin
                        state_nxt = OVERRUN;
                    end else begin
                        pattern_nxt = {pattern[MAX_LEN-2:0], sym_bit};
                        len_nxt     = len + 3'd1;
                    end
                end else if (is_send) begin
                    push        = 1'b1;
                    push_char   = dec_valid ? dec_char : 8'h3F;
                    bad         = ~dec_valid;
                    state_nxt   = IDLE;
                    pattern_nxt = '0;
                    len_nxt     = 3'd0;
                end
            end
            OVERRUN: begin
                if (is_send) begin
                    push        = 1'b1;
                    push_char   = 8'h3F;
                    bad         = 1'b1;
                    state_nxt   = IDLE;
                    pattern_nxt = '0;
                    len_nxt     = 3'd0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                pattern_nxt = '0;
                len_nxt     = 3'd0;
            end
        endcase
    end

    assign out_valid = (fifo_count != '0);
    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);
    assign lost      = push & full & ~pop;

    assign letter  = out_valid ? mem[rd_ptr] : 8'h00;
    assign sym_len = len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pattern    <= '0;
            len        <= 3'd0;
            done       <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            err        <= 1'b0;
            drop       <= 1'b0;
        end else begin
            state   <= state_nxt;
            pattern <= pattern_nxt;
            len     <= len_nxt;
            done    <= (state_nxt == IDLE);
            err     <= bad;
            drop    <= lost;
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push_ok)
                fifo_count <= fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem[wr_ptr] <= push_char;
    end

endmodule

// File: tb/tb_morse_decoder_fifo.sv
// Directed bench for morse_decoder_fifo: decode, overrun, queue full/drop,
// same-cycle push/pop and reset flush, with a digits-disabled twin instance.
module tb_morse_decoder_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] inputSignal = 2'b00;
    logic       out_ready = 1'b0;

    logic [7:0] letter, letter0;
    logic       out_valid, out_valid0;
    logic       done, done0;
    logic [2:0] sym_len, sym_len0;
    logic [3:0] fifo_count, fifo_count0;
    logic       err, err0;
    logic       drop, drop0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    morse_decoder_fifo #(.MAX_LEN(5), .FIFO_DEPTH(8), .EN_DIGITS(1)) dut (
        .clk(clk), .reset(reset), .inputSignal(inputSignal),
        .out_ready(out_ready), .letter(letter), .out_valid(out_valid),
        .done(done), .sym_len(sym_len), .fifo_count(fifo_count),
        .err(err), .drop(drop)
    );

    morse_decoder_fifo #(.MAX_LEN(5), .FIFO_DEPTH(8), .EN_DIGITS(0)) dut0 (
        .clk(clk), .reset(reset), .inputSignal(inputSignal),
        .out_ready(out_ready), .letter(letter0), .out_valid(out_valid0),
        .done(done0), .sym_len(sym_len0), .fifo_count(fifo_count0),
        .err(err0), .drop(drop0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] s);
        inputSignal = s;
        tick();
        inputSignal = 2'b00;
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_done", done, 1);
        chk("rst_len", sym_len, 0);
        chk("rst_letter", letter, 8'h00);
        chk("rst_err", err, 0);
        chk("rst_drop", drop, 0);
        reset = 1'b0;
        tick();

        // 'A' with consumer ready
        out_ready = 1'b1;
        sym(2'b01);
        chk("a_len1", sym_len, 1);
        chk("a_done0", done, 0);
        sym(2'b10);
        chk("a_len2", sym_len, 2);
        sym(2'b11);
        chk("a_valid", out_valid, 1);
        chk("a_letter", letter, 8'h41);
        chk("a_done1", done, 1);
        chk("a_len0", sym_len, 0);
        chk("a_err", err, 0);
        tick();
        chk("a_popped", out_valid, 0);

        // dash x5: '0' with digits, '?' plus err without
        for (int i = 0; i < 5; i++) sym(2'b10);
        chk("z_len", sym_len, 5);
        sym(2'b11);
        chk("z_letter", letter, 8'h30);
        chk("z_err", err, 0);
        chk("z0_letter", letter0, 8'h3F);
        chk("z0_err", err0, 1);
        tick();
        chk("z0_err_end", err0, 0);
        chk("z_popped", out_valid, 0);

        // overrun: six dots
        for (int i = 0; i < 5; i++) sym(2'b01);
        chk("ov_len5", sym_len, 5);
        sym(2'b01);
        chk("ov_len_frz", sym_len, 5);
        chk("ov_done", done, 0);
        sym(2'b11);
        chk("ov_letter", letter, 8'h3F);
        chk("ov_err", err, 1);
        chk("ov_done1", done, 1);
        tick();
        chk("ov_err_end", err, 0);

        // send in IDLE -> space
        sym(2'b11);
        chk("sp_letter", letter, 8'h20);
        chk("sp_valid", out_valid, 1);
        tick();
        chk("sp_popped", out_valid, 0);

        // nine 'E' with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sym(2'b01);
            sym(2'b11);
            chk("full_drop", drop, (i == 8) ? 1 : 0);
            chk("full_count", fifo_count, (i < 8) ? i + 1 : 8);
        end
        chk("full_done", done, 1);
        tick();
        chk("full_drop_end", drop, 0);
        chk("full_hold", letter, 8'h45);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_letter", letter, 8'h45);
            tick();
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_count", fifo_count, 0);

        // full FIFO, push 'T' while popping
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sym(2'b01);
            sym(2'b11);
        end
        chk("pp_full", fifo_count, 8);
        sym(2'b10);
        out_ready = 1'b1;
        sym(2'b11);
        chk("pp_count", fifo_count, 8);
        chk("pp_drop", drop, 0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_letter", letter, (i < 7) ? 8'h45 : 8'h54);
            tick();
        end
        chk("pp_empty", out_valid, 0);

        // reset flushes queue and partial character
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sym(2'b01);
            sym(2'b11);
        end
        sym(2'b10);
        sym(2'b01);
        chk("rf_count3", fifo_count, 3);
        chk("rf_len2", sym_len, 2);
        reset = 1'b1;
        inputSignal = 2'b11;
        out_ready = 1'b1;
        tick();
        chk("rf_valid", out_valid, 0);
        chk("rf_count", fifo_count, 0);
        chk("rf_done", done, 1);
        chk("rf_len", sym_len, 0);
        reset = 1'b0;
        inputSignal = 2'b00;
        tick();
        chk("rf_still", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
